// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer:
// FSM states, opcode length codes, length decode, default timeout.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHECK,
    S_HOLD
  } state_t;

  localparam logic [1:0] LEN_0   = 2'b00;
  localparam logic [1:0] LEN_1   = 2'b01;
  localparam logic [1:0] LEN_4   = 2'b10;
  localparam logic [1:0] LEN_RSV = 2'b11;

  localparam int TO_TICKS_DEF = 640;

  function automatic logic [2:0] len_bytes(input logic [1:0] code);
    logic [2:0] n;
    n = 3'd0;
    unique case (code)
      LEN_1:   n = 3'd1;
      LEN_4:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_timeout.sv
// Inter-byte timeout counter driven by oversampling ticks.
// Ports: i_clk, i_reset_n, i_clr (sync clear), i_en (tick), o_expire (terminal pulse).
module uart_cmd_timeout #(
  parameter int TO_TICKS = 640,
  parameter int TO_W     = 10
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            at_last;

  assign at_last  = (cnt_q == TO_W'(TO_TICKS - 1));
  // Expiry is combinational; the sequencer registers the pulse.
  assign o_expire = i_en && !i_clr && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || o_expire) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frames UART bytes (opcode + 0/1/4 operand bytes) into commands with
// valid/ready output, overrun/timeout/bad-opcode pulses. Optional
// trailing XOR checksum byte under `UART_CMD_CHECKSUM_EN (adds o_csum_err).
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int TO_TICKS = TO_TICKS_DEF,
  parameter int TO_W     = 10
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_s_tick,
  input  logic            i_rx_done_tick,
  input  logic [DBIT-1:0] i_rx_data,
  input  logic            i_cmd_ready,
  output logic            o_cmd_valid,
  output logic [7:0]      o_opcode,
  output logic [31:0]     o_operand,
  output logic            o_overrun,
  output logic            o_timeout,
  output logic            o_bad_op
`ifdef UART_CMD_CHECKSUM_EN
  ,output logic           o_csum_err
`endif
);

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] operand_q, operand_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;
  logic        bad_op_q, bad_op_d;
  logic        expire;
  logic        to_clr;
  logic        last_byte;
  state_t      frame_end;

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  logic        csum_err_q, csum_err_d;
  assign frame_end = S_CHECK;
`else
  assign frame_end = S_HOLD;
`endif

  // Counter runs only while a frame is partially received.
  assign to_clr = i_rx_done_tick ||
                  !(state_q == S_PAYLOAD || state_q == S_CHECK);

  uart_cmd_timeout #(
    .TO_TICKS (TO_TICKS),
    .TO_W     (TO_W)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (to_clr),
    .i_en      (i_s_tick),
    .o_expire  (expire)
  );

  assign last_byte = ((cnt_q + 3'd1) == len_bytes(opcode_q[7:6]));

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;
    bad_op_d  = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    csum_d     = csum_q;
    csum_err_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_rx_done_tick) begin
          opcode_d  = i_rx_data[7:0];
          operand_d = '0;
          cnt_d     = '0;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d    = i_rx_data[7:0];
`endif
          unique case (i_rx_data[7:6])
            LEN_0:   state_d  = frame_end;
            LEN_RSV: bad_op_d = 1'b1;
            default: state_d  = S_PAYLOAD;
          endcase
        end
      end
      S_PAYLOAD: begin
        if (i_rx_done_tick) begin
          operand_d[{cnt_q[1:0], 3'b000} +: 8] = i_rx_data[7:0];
          cnt_d = cnt_q + 3'd1;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d = csum_q ^ i_rx_data[7:0];
`endif
          if (last_byte) begin
            state_d = frame_end;
          end
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_CHECK: begin
        if (i_rx_done_tick) begin
          if (i_rx_data[7:0] == csum_q) begin
            state_d = S_HOLD;
          end else begin
            csum_err_d = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
`endif
      S_HOLD: begin
        // No skid buffer: any byte here is lost, even on the handshake cycle.
        overrun_d = i_rx_done_tick;
        if (i_cmd_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      operand_q <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      bad_op_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      bad_op_q  <= bad_op_d;
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      csum_q     <= '0;
      csum_err_q <= 1'b0;
    end else begin
      csum_q     <= csum_d;
      csum_err_q <= csum_err_d;
    end
  end
  assign o_csum_err = csum_err_q;
`endif

  assign o_cmd_valid = (state_q == S_HOLD);
  assign o_opcode    = opcode_q;
  assign o_operand   = operand_q;
  assign o_overrun   = overrun_q;
  assign o_timeout   = timeout_q;
  assign o_bad_op    = bad_op_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed self-checking bench for uart_cmd_sequencer.
// Checksum cases run when UART_CMD_CHECKSUM_EN is defined.
module tb_uart_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        s_tick;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        ready;
  logic        valid;
  logic [7:0]  opcode;
  logic [31:0] operand;
  logic        overrun;
  logic        timeout;
  logic        bad_op;
`ifdef UART_CMD_CHECKSUM_EN
  logic        csum_err;
`endif

  int total;
  int passed;

  uart_cmd_sequencer dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_s_tick       (s_tick),
    .i_rx_done_tick (rx_done),
    .i_rx_data      (rx_data),
    .i_cmd_ready    (ready),
    .o_cmd_valid    (valid),
    .o_opcode       (opcode),
    .o_operand      (operand),
    .o_overrun      (overrun),
    .o_timeout      (timeout),
    .o_bad_op       (bad_op)
`ifdef UART_CMD_CHECKSUM_EN
    ,.o_csum_err    (csum_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  // Trailing checksum byte only exists in the checksum build.
  task automatic fin(input logic [7:0] cs);
`ifdef UART_CMD_CHECKSUM_EN
    send(cs);
`else
    cs = cs;
`endif
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    rst_n   = 1'b0;
    s_tick  = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    ready   = 1'b0;
    step();
    step();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_operand", operand, 32'd0);
    check("rst_pulses", {29'd0, overrun, timeout, bad_op}, 32'd0);
    rst_n = 1'b1;
    step();

    // Zero-operand command, ready held high
    ready = 1'b1;
    send(8'h05);
    fin(8'h05);
    check("c0_valid", 32'(valid), 32'd1);
    check("c0_opcode", 32'(opcode), 32'h05);
    check("c0_operand", operand, 32'h0);
    step();
    check("c0_drop", 32'(valid), 32'd0);
    ready = 1'b0;

    // Four-byte operand, little-endian
    send(8'h81);
    send(8'h78);
    send(8'h56);
    send(8'h34);
    check("c4_notyet", 32'(valid), 32'd0);
    send(8'h12);
    fin(8'h89);
    check("c4_valid", 32'(valid), 32'd1);
    check("c4_opcode", 32'(opcode), 32'h81);
    check("c4_operand", operand, 32'h12345678);
    ready = 1'b1;
    step();
    check("c4_drop", 32'(valid), 32'd0);
    ready = 1'b0;

    // One-byte operand held, then overrun
    send(8'h41);
    send(8'hAB);
    fin(8'hEA);
    for (int i = 0; i < 20; i++) step();
    check("c1_held", 32'(valid), 32'd1);
    check("c1_operand", operand, 32'h000000AB);
    send(8'h00);
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_operand", operand, 32'h000000AB);
    step();
    check("ovr_end", 32'(overrun), 32'd0);
    ready = 1'b1;
    step();
    check("c1_drop", 32'(valid), 32'd0);
    ready = 1'b0;

    // Byte and ready together in HOLD: byte still dropped
    send(8'h02);
    fin(8'h02);
    ready = 1'b1;
    send(8'h00);
    check("ovr2_pulse", 32'(overrun), 32'd1);
    check("ovr2_valid", 32'(valid), 32'd0);
    ready = 1'b0;
    step();
    check("ovr2_idle", 32'(valid), 32'd0);

    // Timeout; byte wins over a same-cycle tick
    send(8'h82);
    s_tick = 1'b1;
    for (int i = 0; i < 300; i++) step();
    send(8'h11);
    for (int i = 0; i < 639; i++) step();
    check("to_early", 32'(timeout), 32'd0);
    step();
    s_tick = 1'b0;
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_valid", 32'(valid), 32'd0);
    step();
    check("to_end", 32'(timeout), 32'd0);
    ready = 1'b1;
    send(8'h03);
    fin(8'h03);
    check("to_next_v", 32'(valid), 32'd1);
    check("to_next_op", 32'(opcode), 32'h03);
    check("to_next_opd", operand, 32'h0);
    step();
    ready = 1'b0;

    // Reserved length code
    send(8'hC0);
    check("bad_pulse", 32'(bad_op), 32'd1);
    check("bad_valid", 32'(valid), 32'd0);
    step();
    check("bad_end", 32'(bad_op), 32'd0);
    check("bad_novalid", 32'(valid), 32'd0);

    // Reset in the middle of a frame
    send(8'h81);
    send(8'h01);
    rst_n = 1'b0;
    #1;
    check("mrst_opcode", 32'(opcode), 32'd0);
    check("mrst_operand", operand, 32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("mrst_nocmd", 32'(valid), 32'd0);
    ready = 1'b0;

`ifdef UART_CMD_CHECKSUM_EN
    send(8'h41);
    send(8'h3C);
    send(8'h7D);
    check("cs_ok_valid", 32'(valid), 32'd1);
    check("cs_ok_opd", operand, 32'h0000003C);
    ready = 1'b1;
    step();
    ready = 1'b0;
    send(8'h41);
    send(8'h3C);
    send(8'h00);
    check("cs_err_pulse", 32'(csum_err), 32'd1);
    check("cs_err_valid", 32'(valid), 32'd0);
    step();
    check("cs_err_end", 32'(csum_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Sits behind the UART receiver in the pipeline debug path; consumes the receiver's byte stream (data byte plus 1-cycle done tick).
- Frames bytes into commands: one opcode byte followed by 0, 1 or 4 operand bytes.
- Presents each complete command to the debug unit with a valid/ready handshake.
- Aborts partial frames after an inter-byte timeout counted in baud oversampling ticks.

Parameters:
- DBIT, 8, width of a received byte (fixed at 8; kept for consistency with the receiver).
- TO_TICKS, 640, oversampling ticks allowed between bytes inside a frame (≈4 byte times at 16x).
- TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TO_TICKS.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_s_tick  in  1  baud oversampling enable tick.
- i_rx_done_tick  in  1  one-cycle pulse: i_rx_data holds a new byte.
- i_rx_data  in  8  received byte.
- i_cmd_ready  in  1  consumer accepts the command.
- o_cmd_valid  out  1  command available.
- o_opcode  out  8  opcode byte of the command.
- o_operand  out  32  operand, little-endian assembled, zero-extended.
- o_overrun  out  1  one-cycle pulse: byte dropped while holding a command.
- o_timeout  out  1  one-cycle pulse: partial frame aborted.
- o_bad_op  out  1  one-cycle pulse: reserved length code received.

Behaviour:
- Reset, asynchronous on i_reset_n low:
  - state IDLE; all outputs 0; operand and counters cleared.
  - An in-flight frame is discarded silently.
- Length code is opcode[7:6]: 00 → 0 bytes, 01 → 1 byte, 10 → 4 bytes, 11 → reserved.
- IDLE, on i_rx_done_tick:
  - Latch opcode and clear the operand register.
  - Length 0 → go to HOLD, with o_cmd_valid rising the next cycle.
  - Length 01 or 10 → go to PAYLOAD with byte count = 0 and timeout count = 0.
  - Length 11 → pulse o_bad_op and stay in IDLE.
- PAYLOAD:
  - On i_rx_done_tick, write byte k into operand[8k+7:8k] and increment k.
  - On the last byte, go to HOLD (or to CHECK when the optional feature is enabled).
  - Each i_s_tick with no byte in the same cycle increments the timeout count.
  - Reaching TO_TICKS → pulse o_timeout, go to IDLE, keep the latched opcode/operand invisible (valid stays 0).
  - A byte and a tick in the same cycle: the byte wins and the count resets to 0.
- HOLD:
  - o_cmd_valid = 1; o_opcode and o_operand stay stable until accepted.
  - i_cmd_ready high → transfer that cycle, go to IDLE, o_cmd_valid low the next cycle.
  - i_rx_done_tick while in HOLD → byte dropped, o_overrun pulses.
  - Byte and ready in the same cycle: the byte is still dropped (overrun). No skid buffer.
  - No timeout while in HOLD.
- Latency: last byte's done tick at cycle N → o_cmd_valid high at N+1.
- Throughput: one command per frame; a new opcode byte is accepted the cycle after the handshake completes.
- o_operand bytes not received read as 0. The 1-byte case puts the byte in [7:0].
- Pulse outputs are registered and last exactly one cycle.

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- With the macro defined:
  - Each frame ends with one extra byte, CHECK state, equal to the XOR of the opcode and all operand bytes.
  - Match → HOLD.
  - Mismatch → pulse o_csum_err (extra 1-bit output port, present only under the macro), return to IDLE, no command issued.
  - The timeout applies in CHECK.
- Without the macro: no CHECK state, no o_csum_err port, frames carry no checksum.

Decomposition:
- Package uart_cmd_pkg holds:
  - the state encoding (IDLE, PAYLOAD, CHECK, HOLD);
  - the length-code constants LEN_0 / LEN_1 / LEN_4 / LEN_RSV;
  - a function mapping a length code to a byte count;
  - the default TO_TICKS.
- Sub-module uart_cmd_timeout: a tick-driven counter with clear, enable and a terminal pulse.
- The main FSM and operand assembly stay in uart_cmd_sequencer.

Test Plan:
- Bytes 0x05 with ready held high → o_cmd_valid one cycle, opcode 0x05, operand 0x00000000.
- Bytes 0x81,0x78,0x56,0x34,0x12 → opcode 0x81, operand 0x12345678; valid asserted 1 cycle after the 0x12 tick.
- Bytes 0x41,0xAB with ready low for 20 cycles, then another byte 0x00 → valid held, operand 0x000000AB stable, one o_overrun pulse; ready high → valid drops the next cycle.
- Bytes 0x82,0x11 then 640 i_s_ticks with no byte → o_timeout pulse; a following 0x03 yields command opcode 0x03.
- Byte 0xC0 → o_bad_op pulse, no valid; i_reset_n low mid-PAYLOAD after 0x81,0x01 → all outputs 0 immediately, no command after release.
- (UART_CMD_CHECKSUM_EN) Bytes 0x41,0x3C,0x7D → command issued; bytes 0x41,0x3C,0x00 → o_csum_err pulse, no valid.
